mmr_access_arbiter: RTL and testbench



---
 rtl/mmr_access_arbiter_if.sv | 46 ++++
 rtl/mmr_access_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mmr_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmr_access_arbiter_if.sv
// Bus bundle between the two requesters (CPU LSU, debug bridge), the
// arbiter, and the MMR register file / read mux.
interface mmr_access_arbiter_if #(
   parameter int N_MMR = 13
);
   logic             cpu_req;
   logic             cpu_we;
   logic [31:0]      cpu_addr;
   logic [31:0]      cpu_wdata;
   logic [31:0]      cpu_rdata;
   logic             cpu_ack;
   logic             cpu_err;

   logic             dbg_req;
   logic             dbg_we;
   logic [31:0]      dbg_addr;
   logic [31:0]      dbg_wdata;
   logic [31:0]      dbg_rdata;
   logic             dbg_ack;
   logic             dbg_err;

   logic [3:0]       mmr_sel;
   logic [31:0]      mmr_rdata;
   logic [N_MMR-1:0] mmr_wr_en;
   logic [31:0]      mmr_wdata;

   // arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mmr_rdata,
      output cpu_rdata, cpu_ack, cpu_err,
      output dbg_rdata, dbg_ack, dbg_err,
      output mmr_sel, mmr_wr_en, mmr_wdata
   );

   // requester / register-file side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mmr_rdata,
      input  cpu_rdata, cpu_ack, cpu_err,
      input  dbg_rdata, dbg_ack, dbg_err,
      input  mmr_sel, mmr_wr_en, mmr_wdata
   );
endinterface

// File: rtl/mmr_access_arbiter.sv
// Round-robin arbiter sequencing CPU and debug accesses to the MMR block.
//
// state  | meaning
// IDLE   | sample requests, grant, decode address
// ACCESS | drive mmr_sel, one-cycle write strobe on writes
// WAIT   | hold mmr_sel while read mux settles, capture on last cycle
// RESP   | one-cycle ack/err to the granted requester
module mmr_access_arbiter #(
   parameter logic [31:0] MMR_BASE    = 32'h0000_FF00,
   parameter int          N_MMR       = 13,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mmr_access_arbiter_if.slave  bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;
   localparam logic [3:0] SEL_IDLE = 4'hF;
   localparam logic       GNT_CPU  = 1'b0;
   localparam logic       GNT_DBG  = 1'b1;

   logic [1:0]       state_q, state_d;
   logic [3:0]       sel_q, sel_d;
   logic             we_q, we_d;
   logic             gnt_q, gnt_d;
   logic             last_q, last_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [N_MMR-1:0] wr_en_q, wr_en_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
   logic             dbg_ack_q, dbg_ack_d, dbg_err_q, dbg_err_d;
   logic [31:0]      cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;

   logic             pick_dbg;
   logic             req_we;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [29:0]      off_w;
   logic             addr_ok;
   logic [3:0]       req_idx;
   logic             finish;

   // Requester selection (round-robin on a tie) and address decode
   always_comb begin
      if (bus.cpu_req && bus.dbg_req) pick_dbg = (last_q == GNT_CPU);
      else                            pick_dbg = bus.dbg_req;
      req_we    = pick_dbg ? bus.dbg_we    : bus.cpu_we;
      req_addr  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
      req_wdata = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
      // word offset from the base; base is word aligned
      off_w     = req_addr[31:2] - MMR_BASE[31:2];
      addr_ok   = (req_addr[1:0] == 2'b00) && (off_w < 30'(N_MMR));
      req_idx   = off_w[3:0];
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      we_d        = we_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      wr_en_d     = '0;
      wdata_d     = wdata_q;
      cpu_ack_d   = 1'b0;
      cpu_err_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      dbg_err_d   = 1'b0;
      cpu_rdata_d = '0;
      dbg_rdata_d = '0;
      finish      = 1'b0;

      case (state_q)
         S_IDLE: begin
            sel_d = SEL_IDLE;
            if (bus.cpu_req || bus.dbg_req) begin
               gnt_d  = pick_dbg;
               last_d = pick_dbg;
               we_d   = req_we;
               if (addr_ok) begin
                  state_d = S_ACCESS;
                  sel_d   = req_idx;
                  if (req_we) begin
                     wr_en_d = N_MMR'(1) << req_idx;
                     wdata_d = req_wdata;
                  end
               end else begin
                  state_d = S_RESP;
                  if (pick_dbg) dbg_err_d = 1'b1;
                  else          cpu_err_d = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (WAIT_CYCLES == 0) begin
               finish = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 3'(WAIT_CYCLES - 1);
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) finish = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
         end
         default: begin
            state_d = S_IDLE;
            sel_d   = SEL_IDLE;
         end
      endcase

      // read data is captured on the same edge that enters RESP
      if (finish) begin
         state_d = S_RESP;
         sel_d   = SEL_IDLE;
         if (gnt_q == GNT_DBG) begin
            dbg_ack_d   = 1'b1;
            dbg_rdata_d = we_q ? '0 : bus.mmr_rdata;
         end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = we_q ? '0 : bus.mmr_rdata;
         end
      end
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sel_q       <= SEL_IDLE;
         we_q        <= 1'b0;
         gnt_q       <= GNT_CPU;
         last_q      <= GNT_DBG;
         cnt_q       <= '0;
         wr_en_q     <= '0;
         wdata_q     <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         dbg_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         wdata_q     <= wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_err_q   <= cpu_err_d;
         dbg_ack_q   <= dbg_ack_d;
         dbg_err_q   <= dbg_err_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign bus.mmr_sel   = sel_q;
   assign bus.mmr_wr_en = wr_en_q;
   assign bus.mmr_wdata = wdata_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_err   = cpu_err_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dbg_ack   = dbg_ack_q;
   assign bus.dbg_err   = dbg_err_q;
   assign bus.dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_mmr_access_arbiter.sv
// Scoreboard bench for mmr_access_arbiter: random CPU/debug traffic against a
// transaction-level model, plus reset-abort and wait-latency variants.
`timescale 1ns/1ps
module tb_mmr_access_arbiter;
   localparam int          N_MMR = 13;
   localparam int          W     = 1;
   localparam logic [31:0] BASE  = 32'h0000_FF00;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mmr_access_arbiter_if #(.N_MMR(N_MMR)) bus  ();
   mmr_access_arbiter_if #(.N_MMR(N_MMR)) bus0 ();
   mmr_access_arbiter_if #(.N_MMR(N_MMR)) bus3 ();

   mmr_access_arbiter #(.MMR_BASE(BASE), .N_MMR(N_MMR), .WAIT_CYCLES(W))
      dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   mmr_access_arbiter #(.MMR_BASE(BASE), .N_MMR(N_MMR), .WAIT_CYCLES(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   mmr_access_arbiter #(.MMR_BASE(BASE), .N_MMR(N_MMR), .WAIT_CYCLES(3))
      dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   // register file behind the main arbiter
   logic [31:0] init_regs [N_MMR];
   logic [31:0] hw_regs   [N_MMR];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_MMR; i++) hw_regs[i] <= init_regs[i];
      end else begin
         for (int i = 0; i < N_MMR; i++) if (bus.mmr_wr_en[i]) hw_regs[i] <= bus.mmr_wdata;
      end
   end
   assign bus.mmr_rdata  = (int'(bus.mmr_sel) < N_MMR) ? hw_regs[int'(bus.mmr_sel)] : 32'hFFFF_FFFF;
   assign bus0.mmr_rdata = {28'hC0DE000, bus0.mmr_sel};
   assign bus3.mmr_rdata = {28'hC0DE000, bus3.mmr_sel};

   // reference model
   typedef struct { bit dbg; bit err; logic [31:0] rdata; int cyc; } resp_t;
   typedef struct { int idx; logic [31:0] data; int cyc; } wr_t;
   resp_t       resp_q[$];
   wr_t         wr_q[$];
   logic [31:0] mdl_regs [N_MMR];
   bit          mdl_last_dbg;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Predicts one access granted at edge g; returns the cycle its ack/err is visible.
   function automatic int predict(bit dbg, bit we, logic [31:0] addr, logic [31:0] wd, int g);
      logic [31:0] off;
      int          idx;
      resp_t       r;
      wr_t         w;
      off   = addr - BASE;
      idx   = int'(off / 4);
      r.dbg = dbg;
      r.err = !((addr % 4 == 0) && (off / 4 < N_MMR));
      r.rdata = '0;
      if (r.err) begin
         r.cyc = g;
      end else begin
         r.cyc = g + W + 1;
         if (we) begin
            mdl_regs[idx] = wd;
            w.idx = idx; w.data = wd; w.cyc = g;
            wr_q.push_back(w);
         end else begin
            r.rdata = mdl_regs[idx];
         end
      end
      resp_q.push_back(r);
      return r.cyc;
   endfunction

   // monitor: compares every response and write strobe with the scoreboard
   always @(negedge clk) begin : mon
      resp_t      e;
      wr_t        w;
      logic [3:0] evs;
      if (rst_n) begin
         evs = {bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err};
         if (evs != 4'd0) begin
            if (resp_q.size() == 0) begin
               check("unexpected_resp", 32'(evs), 32'd0);
            end else begin
               e = resp_q.pop_front();
               check("resp_kind", 32'(evs), e.dbg ? (e.err ? 32'd1 : 32'd2) : (e.err ? 32'd4 : 32'd8));
               check("resp_cycle", cyc, e.cyc);
               check("rdata_own", e.dbg ? bus.dbg_rdata : bus.cpu_rdata, e.rdata);
               check("rdata_other", e.dbg ? bus.cpu_rdata : bus.dbg_rdata, 32'd0);
               check("sel_in_resp", 32'(bus.mmr_sel), 32'hF);
            end
         end else if (bus.cpu_rdata != 0 || bus.dbg_rdata != 0) begin
            check("rdata_outside_resp", bus.cpu_rdata | bus.dbg_rdata, 32'd0);
         end
         if (bus.mmr_wr_en != '0) begin
            if (wr_q.size() == 0) begin
               check("unexpected_wr", 32'(bus.mmr_wr_en), 32'd0);
            end else begin
               w = wr_q.pop_front();
               check("wr_en", 32'(bus.mmr_wr_en), 32'(1) << w.idx);
               check("wr_data", bus.mmr_wdata, w.data);
               check("wr_cycle", cyc, w.cyc);
               check("wr_sel", 32'(bus.mmr_sel), w.idx);
            end
         end
      end
   end

   task automatic do_round(bit uc, bit ud, bit cw, logic [31:0] ca, logic [31:0] cd,
                           bit dw, logic [31:0] da, logic [31:0] dd);
      int g, a1, budget;
      bit first_dbg;
      @(negedge clk);
      g = cyc + 1;
      if (uc && ud) begin
         first_dbg = !mdl_last_dbg;
         if (first_dbg) begin
            a1 = predict(1'b1, dw, da, dd, g);
            void'(predict(1'b0, cw, ca, cd, a1 + 2));
         end else begin
            a1 = predict(1'b0, cw, ca, cd, g);
            void'(predict(1'b1, dw, da, dd, a1 + 2));
         end
         mdl_last_dbg = !first_dbg;
      end else if (uc) begin
         void'(predict(1'b0, cw, ca, cd, g));
         mdl_last_dbg = 1'b0;
      end else if (ud) begin
         void'(predict(1'b1, dw, da, dd, g));
         mdl_last_dbg = 1'b1;
      end
      bus.cpu_req = uc; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.dbg_req = ud; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
      budget = 0;
      while ((bus.cpu_req || bus.dbg_req) && budget < 40) begin
         @(negedge clk);
         budget++;
         if (bus.cpu_ack || bus.cpu_err) bus.cpu_req = 1'b0;
         if (bus.dbg_ack || bus.dbg_err) bus.dbg_req = 1'b0;
      end
      if (bus.cpu_req || bus.dbg_req) begin
         check("round_timeout", {30'd0, bus.cpu_req, bus.dbg_req}, 32'd0);
         bus.cpu_req = 1'b0;
         bus.dbg_req = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int k;
      k = $urandom_range(0, 9);
      if (k < 7) return BASE + 32'(4 * $urandom_range(0, N_MMR - 1));
      if (k == 7) return BASE + 32'(4 * $urandom_range(N_MMR, 40));
      if (k == 8) return BASE + 32'(4 * $urandom_range(0, N_MMR - 1)) + 32'($urandom_range(1, 3));
      return BASE - 32'(4 * $urandom_range(1, 16));
   endfunction

   task automatic check_reset_outputs(string tag);
      check({tag, "_sel"}, 32'(bus.mmr_sel), 32'hF);
      check({tag, "_wr_en"}, 32'(bus.mmr_wr_en), 32'd0);
      check({tag, "_wdata"}, bus.mmr_wdata, 32'd0);
      check({tag, "_ack_err"}, {28'd0, bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err}, 32'd0);
      check({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
      check({tag, "_dbg_rdata"}, bus.dbg_rdata, 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int g, seen0, seen3;
      for (int i = 0; i < N_MMR; i++) init_regs[i] = $urandom;
      init_regs[2] = 32'hDEAD_BEEF;
      for (int i = 0; i < N_MMR; i++) mdl_regs[i] = init_regs[i];
      mdl_last_dbg = 1'b1;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
      bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
      bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;
      bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
      bus3.dbg_req = 0; bus3.dbg_we = 0; bus3.dbg_addr = 0; bus3.dbg_wdata = 0;

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;

      // directed accesses
      do_round(1, 0, 0, 32'h0000_FF08, 0, 0, 0, 0);
      do_round(0, 1, 0, 0, 0, 1, 32'h0000_FF30, 32'h1234_5678);
      do_round(1, 1, 0, BASE + 32'd4, 0, 0, BASE + 32'd8, 0);
      do_round(1, 1, 1, BASE + 32'd12, 32'hA5A5_0001, 0, BASE + 32'd12, 0);
      do_round(1, 0, 0, 32'h0000_FF34, 0, 0, 0, 0);
      do_round(0, 1, 0, 0, 0, 1, 32'h0000_FF05, 32'h5555_AAAA);
      do_round(1, 0, 1, 32'h0000_FEFC, 32'h0BAD_F00D, 0, 0, 0);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         bit uc, ud;
         uc = $urandom_range(0, 1);
         ud = $urandom_range(0, 1);
         if (!uc && !ud) uc = 1'b1;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_round(uc, ud, 1'($urandom), rand_addr(), $urandom,
                  1'($urandom), rand_addr(), $urandom);
      end

      // reset asserted while a read sits in WAIT
      @(negedge clk);
      g = cyc + 1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = BASE + 32'd20;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      bus.cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ack_during_reset",
               {28'd0, bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err}, 32'd0);
         check("sel_during_reset", 32'(bus.mmr_sel), 32'hF);
      end
      rst_n = 1'b1;
      for (int i = 0; i < N_MMR; i++) mdl_regs[i] = init_regs[i];
      mdl_last_dbg = 1'b1;
      repeat (3) @(negedge clk);
      do_round(1, 1, 0, BASE + 32'd8, 0, 0, BASE + 32'd16, 0);
      do_round(1, 0, 0, BASE + 32'd20, 0, 0, 0, 0);

      // same read against WAIT_CYCLES=0 and WAIT_CYCLES=3 builds
      @(negedge clk);
      g = cyc + 1;
      bus0.cpu_req = 1'b1; bus0.cpu_addr = 32'h0000_FF08;
      bus3.cpu_req = 1'b1; bus3.cpu_addr = 32'h0000_FF08;
      seen0 = -100;
      seen3 = -100;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus0.cpu_ack && bus0.cpu_req) begin
            seen0 = cyc;
            bus0.cpu_req = 1'b0;
            check("w0_rdata", bus0.cpu_rdata, 32'hC0DE_0002);
         end
         if (bus3.cpu_ack && bus3.cpu_req) begin
            seen3 = cyc;
            bus3.cpu_req = 1'b0;
            check("w3_rdata", bus3.cpu_rdata, 32'hC0DE_0002);
         end
      end
      check("w0_latency", seen0 - g + 1, 32'd2);
      check("w3_latency", seen3 - g + 1, 32'd5);

      repeat (4) @(negedge clk);
      check("resp_queue_drained", resp_q.size(), 32'd0);
      check("wr_queue_drained", wr_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
